// File: rtl/mult_seq_core.sv
// Sequential shift-and-add unsigned multiplier: WIDTH+1 edges from init sample to done (fewer with MULT_EARLY_EXIT_EN).
// Level init handshake: init is ignored while busy; init must drop for one edge before the next start.
module mult_seq_core #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [WIDTH-1:0]     op_A,
    input  logic [WIDTH-1:0]     op_B,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   areg;
    logic [WIDTH-1:0]     breg;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_iter;

    always_comb begin
        acc_next  = acc;
        last_iter = 1'b0;
        if (breg[0]) begin
            acc_next = acc + areg;
        end
        last_iter = (cnt == CW'(WIDTH - 1));
`ifdef MULT_EARLY_EXIT_EN
        // Nothing left to add once the remaining multiplier bits are all zero.
        if ((breg >> 1) == '0) begin
            last_iter = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            areg   <= '0;
            breg   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (init) begin
                        areg  <= {{WIDTH{1'b0}}, op_A};
                        breg  <= op_B;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc  <= acc_next;
                    areg <= areg << 1;
                    breg <= breg >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last_iter) begin
                        result <= acc_next;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy <= 1'b0;
                    // Holding init high parks here; a restart needs init low first.
                    if (!init) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_core.sv
// Randomized bench for mult_seq_core against an arithmetic product/latency model.
module tb_mult_seq_core;
    localparam int WIDTH = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               init;
    logic [WIDTH-1:0]   op_A;
    logic [WIDTH-1:0]   op_B;
    logic [2*WIDTH-1:0] result;
    logic               done;
    logic               busy;

    int                 vec_cnt  = 0;
    int                 miss_cnt = 0;
    logic [2*WIDTH-1:0] last_prod = '0;

    mult_seq_core #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .init   (init),
        .op_A   (op_A),
        .op_B   (op_B),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Edges after the init-sampling edge until done is visible.
    function automatic int exp_latency(input logic [WIDTH-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int hb;
        hb = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) hb = i + 1;
        end
        return (hb < 1) ? 1 : hb;
`else
        return WIDTH;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit scramble);
        int                 n;
        int                 busy_n;
        bit                 held;
        logic [2*WIDTH-1:0] expv;
        expv = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        op_A = a;
        op_B = b;
        init = 1'b1;
        tick();
        n = 0;
        busy_n = 0;
        held = 1'b1;
        while (!done && n < 200) begin
            if (busy) busy_n++;
            if (result !== last_prod) held = 1'b0;
            if (scramble) begin
                op_A = WIDTH'($urandom);
                op_B = WIDTH'($urandom);
            end
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(exp_latency(b)));
        chk("busy_cycles", 64'(busy_n), 64'(exp_latency(b)));
        chk("result_held_during_calc", 64'(held), 64'(1));
        chk("product", 64'(result), 64'(expv));
        chk("busy_in_done", 64'(busy), 64'(0));
        last_prod = expv;
    endtask

    task automatic release_init();
        init = 1'b0;
        tick();
        chk("done_fall", 64'(done), 64'(0));
    endtask

    initial begin
        bit stable;
        reset = 1'b1;
        init  = 1'b0;
        op_A  = '0;
        op_B  = '0;
        tick();
        tick();
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        tick();

        run_mult(16'd3, 16'd5, 1'b0);
        release_init();
        run_mult(16'hFFFF, 16'hFFFF, 1'b0);
        release_init();
        run_mult(16'h1234, 16'h0000, 1'b0);
        release_init();
        run_mult(16'h0000, 16'hABCD, 1'b0);
        release_init();
        run_mult(16'hBEEF, 16'h0001, 1'b0);
        release_init();
        run_mult(16'h0003, 16'h0010, 1'b0);
        release_init();
        run_mult(16'h0001, 16'h8000, 1'b0);
        release_init();

        // Long init hold after done: no restart, product stays put.
        run_mult(16'h00AA, 16'h0055, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b1 || busy !== 1'b0 || result !== last_prod) stable = 1'b0;
        end
        chk("hold_no_restart", 64'(stable), 64'(1));
        release_init();
        run_mult(16'd7, 16'd9, 1'b0);
        release_init();

        run_mult(16'h00FF, 16'h0100, 1'b1);
        release_init();

        // Reset in the middle of a multiply.
        op_A = 16'h1234;
        op_B = 16'h5678;
        init = 1'b1;
        tick();
        repeat (8) tick();
        chk("midop_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        init  = 1'b0;
        tick();
        reset = 1'b0;
        chk("abort_result", 64'(result), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        last_prod = '0;
        tick();
        tick();
        chk("abort_stays_idle", 64'(busy), 64'(0));
        run_mult(16'd2, 16'd2, 1'b0);
        release_init();

        // Reset and init together: reset wins.
        op_A  = 16'h0011;
        op_B  = 16'h0022;
        reset = 1'b1;
        init  = 1'b1;
        tick();
        chk("rst_vs_init_busy", 64'(busy), 64'(0));
        chk("rst_vs_init_result", 64'(result), 64'(0));
        reset = 1'b0;
        init  = 1'b0;
        last_prod = '0;
        tick();

        for (int k = 0; k < 20; k++) begin
            run_mult(WIDTH'($urandom), WIDTH'($urandom >> (k % 16)), k[0]);
            release_init();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
